// File: rtl/inst_sram_resp_pkg.sv
// Shared constants for the instruction SRAM responder: window defaults and byte-lane merge helper.
package inst_sram_resp_pkg;

    localparam logic [31:0] ADDR_BASE_DEF   = 32'h1c00_0000;
    localparam int          DEPTH_WORDS_DEF = 4096;
    localparam int          LANE_W          = 8;
    localparam int          NUM_LANES       = 4;

    // Old word with every enabled byte lane replaced by the new data.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0]          old_word,
        input logic [31:0]          new_word,
        input logic [NUM_LANES-1:0] be
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (be[i]) begin
                res[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_word_array.sv
// Word storage split into byte-lane arrays: one lane-masked write port, one full-word
// write port and one registered read-first read port. No reset; contents survive rstn.
module sram_word_array
    import inst_sram_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [NUM_LANES-1:0] wr_be,
    input  logic [AW-1:0]        wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 ld_we,
    input  logic [AW-1:0]        ld_addr,
    input  logic [31:0]          ld_data,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [31:0]          rd_data
);

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] mem_lane [DEPTH_WORDS];
            logic [LANE_W-1:0] rd_lane_reg;

            // Masked port is applied last so it wins if both ports target one word.
            always_ff @(posedge clk) begin
                if (ld_we) begin
                    mem_lane[ld_addr] <= ld_data[gi*LANE_W +: LANE_W];
                end
                if (wr_en && wr_be[gi]) begin
                    mem_lane[wr_addr] <= wr_data[gi*LANE_W +: LANE_W];
                end
                if (rd_en) begin
                    rd_lane_reg <= mem_lane[rd_addr];
                end
            end

            assign rd_data[gi*LANE_W +: LANE_W] = rd_lane_reg;
        end
    endgenerate

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: 1-cycle read, byte-lane writes, side preload, error/access tracking.
// Define INST_SRAM_WRITE_FIRST_EN to return the merged word on write cycles (default read-first).
module inst_sram_resp
    import inst_sram_resp_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
    parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_conflict,
    output logic        addr_err,
    output logic [31:0] acc_cnt
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   main_off, ld_off;
    logic          main_hit, ld_hit;
    logic [AW-1:0] main_idx, ld_idx;
    logic          acc_ok, is_wr;
    logic          arr_wr_en, arr_ld_we, arr_rd_en, conflict;
    logic [31:0]   arr_rd_data;

    logic          resp_zero_reg;
    logic          addr_err_reg;
    logic          ld_conflict_reg;
    logic [31:0]   acc_cnt_reg;

    // Addresses below the base wrap to huge offsets and miss.
    assign main_off = inst_sram_addr - ADDR_BASE;
    assign ld_off   = ld_addr - ADDR_BASE;
    assign main_hit = (main_off >> (AW + 2)) == 32'd0;
    assign ld_hit   = (ld_off >> (AW + 2)) == 32'd0;
    assign main_idx = main_off[AW+1:2];
    assign ld_idx   = ld_off[AW+1:2];

    assign acc_ok    = rstn && inst_sram_en;
    assign is_wr     = |inst_sram_we;
    assign arr_wr_en = acc_ok && is_wr && main_hit;
    assign arr_rd_en = acc_ok && main_hit;
    assign conflict  = arr_wr_en && ld_en && ld_hit && (main_idx == ld_idx);
    assign arr_ld_we = rstn && ld_en && ld_hit && !conflict;

    sram_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_be   (inst_sram_we),
        .wr_addr (main_idx),
        .wr_data (inst_sram_wdata),
        .ld_we   (arr_ld_we),
        .ld_addr (ld_idx),
        .ld_data (ld_data),
        .rd_en   (arr_rd_en),
        .rd_addr (main_idx),
        .rd_data (arr_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_zero_reg   <= 1'b1;
            addr_err_reg    <= 1'b0;
            ld_conflict_reg <= 1'b0;
            acc_cnt_reg     <= 32'd0;
        end else begin
            ld_conflict_reg <= conflict;
            if (inst_sram_en) begin
                acc_cnt_reg   <= acc_cnt_reg + 32'd1;
                resp_zero_reg <= !main_hit;
                if (!main_hit) begin
                    addr_err_reg <= 1'b1;
                end
            end
        end
    end

`ifdef INST_SRAM_WRITE_FIRST_EN
    // The array returns the pre-write word; the write lanes are re-applied on the response side.
    logic        resp_merge_reg;
    logic [3:0]  merge_be_reg;
    logic [31:0] merge_wdata_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_merge_reg  <= 1'b0;
            merge_be_reg    <= 4'd0;
            merge_wdata_reg <= 32'd0;
        end else if (inst_sram_en) begin
            resp_merge_reg  <= is_wr;
            merge_be_reg    <= inst_sram_we;
            merge_wdata_reg <= inst_sram_wdata;
        end
    end

    assign inst_sram_rdata = resp_zero_reg  ? 32'd0 :
                             resp_merge_reg ? merge_lanes(arr_rd_data, merge_wdata_reg, merge_be_reg) :
                                              arr_rd_data;
`else
    assign inst_sram_rdata = resp_zero_reg ? 32'd0 : arr_rd_data;
`endif

    assign ld_conflict = ld_conflict_reg;
    assign addr_err    = addr_err_reg;
    assign acc_cnt     = acc_cnt_reg;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Directed bench for inst_sram_resp: per-cycle compare against a word-level model plus literal checks.
// Honours INST_SRAM_WRITE_FIRST_EN the same way as the design.
module tb_inst_sram_resp;

    localparam logic [31:0] BASE  = 32'h1c00_0000;
    localparam int          DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        inst_sram_en = 1'b0;
    logic [3:0]  inst_sram_we = 4'd0;
    logic [31:0] inst_sram_addr = 32'd0;
    logic [31:0] inst_sram_wdata = 32'd0;
    logic [31:0] inst_sram_rdata;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = 32'd0;
    logic [31:0] ld_data = 32'd0;
    logic        ld_conflict;
    logic        addr_err;
    logic [31:0] acc_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_on = 1'b0;

    // Model state
    logic [31:0] mem_m   [int];
    logic [31:0] m_rdata = 32'd0;
    bit          m_rknown = 1'b0;
    bit          m_err = 1'b0;
    bit          m_conf = 1'b0;
    logic [31:0] m_acc = 32'd0;

    inst_sram_resp dut (
        .clk             (clk),
        .rstn            (rstn),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .ld_en           (ld_en),
        .ld_addr         (ld_addr),
        .ld_data         (ld_data),
        .ld_conflict     (ld_conflict),
        .addr_err        (addr_err),
        .acc_cnt         (acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(DEPTH * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off / 32'd4);
    endfunction

    // Applies the access rules to the inputs present at this edge.
    task automatic model_edge();
        int          mi, li;
        bit          mh, lh, wr, known_old;
        logic [31:0] old_w, new_w;
        if (!rstn) begin
            m_rdata = 32'd0; m_rknown = 1'b1; m_err = 1'b0; m_conf = 1'b0; m_acc = 32'd0;
            return;
        end
        mh = in_win(inst_sram_addr); mi = widx(inst_sram_addr);
        lh = in_win(ld_addr);        li = widx(ld_addr);
        wr = (inst_sram_we != 4'd0);
        known_old = mh && mem_m.exists(mi);
        old_w = known_old ? mem_m[mi] : 32'd0;
        m_conf = 1'b0;
        if (inst_sram_en) begin
            m_acc = m_acc + 32'd1;
            if (!mh) begin
                m_rdata = 32'd0; m_rknown = 1'b1; m_err = 1'b1;
            end else if (!wr) begin
                m_rdata = old_w; m_rknown = known_old;
            end else begin
                new_w = old_w;
                for (int b = 0; b < 4; b++)
                    if (inst_sram_we[b]) new_w[8*b +: 8] = inst_sram_wdata[8*b +: 8];
`ifdef INST_SRAM_WRITE_FIRST_EN
                m_rdata = new_w; m_rknown = known_old || (inst_sram_we == 4'hf);
`else
                m_rdata = old_w; m_rknown = known_old;
`endif
                if (known_old || inst_sram_we == 4'hf) mem_m[mi] = new_w;
            end
        end
        if (ld_en && lh) begin
            if (inst_sram_en && wr && mh && (mi == li)) m_conf = 1'b1;
            else mem_m[li] = ld_data;
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            if (m_rknown) chk("rdata", inst_sram_rdata, m_rdata);
            chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
            chk("ld_conflict", {31'd0, ld_conflict}, {31'd0, m_conf});
            chk("acc_cnt", acc_cnt, m_acc);
        end
    end

    task automatic step(input bit rn, input bit en, input logic [3:0] we, input logic [31:0] a,
                        input logic [31:0] wd, input bit le, input logic [31:0] la, input logic [31:0] ldv);
        rstn = rn; inst_sram_en = en; inst_sram_we = we; inst_sram_addr = a; inst_sram_wdata = wd;
        ld_en = le; ld_addr = la; ld_data = ldv;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        $display("step rstn=%0b en=%0b we=%h addr=%08h wd=%08h ld=%0b@%08h=%08h -> rdata=%08h err=%0b conf=%0b acc=%0d",
                 rn, en, we, a, wd, le, la, ldv, inst_sram_rdata, addr_err, ld_conflict, acc_cnt);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b1, 4'd0, a, 32'd0, 1'b0, 32'd0, 32'd0);
    endtask
    task automatic wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        step(1'b1, 1'b1, we, a, d, 1'b0, 32'd0, 32'd0);
    endtask
    task automatic ld(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, a, d);
    endtask
    task automatic idle();
        step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        cmp_on = 1'b1;
        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        chk("lit_reset_rdata", inst_sram_rdata, 32'd0);
        chk("lit_reset_acc", acc_cnt, 32'd0);

        ld(32'h1c00_0000, 32'h0280_0421);
        ld(32'h1c00_0004, 32'h1122_3344);
        ld(32'h1c00_0008, 32'h0000_0000);
        ld(32'h1c00_3ffc, 32'hcafe_f00d);
        ld(32'h1c00_4000, 32'hdead_beef);
        chk("lit_oow_preload_no_err", {31'd0, addr_err}, 32'd0);

        rd(32'h1c00_0000);
        chk("lit_first_read", inst_sram_rdata, 32'h0280_0421);
        chk("lit_first_acc", acc_cnt, 32'd1);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("lit_hold", inst_sram_rdata, 32'h0280_0421);
        end

        wr(32'h1c00_0004, 4'b0101, 32'haabb_ccdd);
`ifdef INST_SRAM_WRITE_FIRST_EN
        chk("lit_write_cycle", inst_sram_rdata, 32'h11bb_33dd);
`else
        chk("lit_write_cycle", inst_sram_rdata, 32'h1122_3344);
`endif
        rd(32'h1c00_0004);
        chk("lit_merge_readback", inst_sram_rdata, 32'h11bb_33dd);
        rd(32'h1c00_3ffc);
        chk("lit_top_word", inst_sram_rdata, 32'hcafe_f00d);

        rd(32'h1bff_fffc);
        chk("lit_below_rdata", inst_sram_rdata, 32'd0);
        chk("lit_below_err", {31'd0, addr_err}, 32'd1);
        rd(32'h1c00_4000);
        chk("lit_above_rdata", inst_sram_rdata, 32'd0);
        rd(32'h1c00_0000);
        chk("lit_err_sticky", {31'd0, addr_err}, 32'd1);
        chk("lit_hit_after_err", inst_sram_rdata, 32'h0280_0421);
        wr(32'h1c00_4000, 4'hf, 32'h1234_5678);
        chk("lit_oow_write_rdata", inst_sram_rdata, 32'd0);

        step(1'b1, 1'b1, 4'hf, 32'h1c00_0008, 32'h1, 1'b1, 32'h1c00_0008, 32'h2);
        chk("lit_conflict_pulse", {31'd0, ld_conflict}, 32'd1);
        idle();
        chk("lit_conflict_drop", {31'd0, ld_conflict}, 32'd0);
        rd(32'h1c00_0008);
        chk("lit_conflict_data", inst_sram_rdata, 32'h1);

        step(1'b1, 1'b1, 4'hf, 32'h1c00_000c, 32'h55, 1'b1, 32'h1c00_0010, 32'h66);
        chk("lit_diff_no_conflict", {31'd0, ld_conflict}, 32'd0);
        rd(32'h1c00_000c);
        chk("lit_diff_main", inst_sram_rdata, 32'h55);
        rd(32'h1c00_0010);
        chk("lit_diff_ld", inst_sram_rdata, 32'h66);

        step(1'b1, 1'b1, 4'd0, 32'h1c00_0010, 32'd0, 1'b1, 32'h1c00_0010, 32'h77);
        chk("lit_rd_ld_old", inst_sram_rdata, 32'h66);
        rd(32'h1c00_0010);
        chk("lit_rd_ld_new", inst_sram_rdata, 32'h77);

        rd(32'h1c00_0000);
        step(1'b0, 1'b1, 4'hf, 32'h1c00_0000, 32'hffff_ffff, 1'b0, 32'd0, 32'd0);
        chk("lit_midreset_rdata", inst_sram_rdata, 32'd0);
        chk("lit_midreset_acc", acc_cnt, 32'd0);
        chk("lit_midreset_err", {31'd0, addr_err}, 32'd0);
        rd(32'h1c00_0000);
        chk("lit_after_reset_data", inst_sram_rdata, 32'h0280_0421);
        chk("lit_after_reset_acc", acc_cnt, 32'd1);

        idle();
        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
